// File: rtl/park_pkg.sv
// Shared constants for the park entry controller: park IDs, FSM encoding,
// field widths and button lane indices.
package park_pkg;
  localparam int CNT_W   = 3;
  localparam int PRICE_W = 2;

  localparam logic [CNT_W-1:0] PARK_NONE = 3'd0;
  localparam logic [CNT_W-1:0] PARK_A    = 3'd1;
  localparam logic [CNT_W-1:0] PARK_B    = 3'd2;

  typedef enum logic [1:0] {IDLE, SEL, GATE} state_t;

  localparam int NUM_BTN    = 5;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_ENTER  = 2;
  localparam int BTN_EXIT_A = 3;
  localparam int BTN_EXIT_B = 4;
endpackage

// File: rtl/park_entry_controller_if.sv
// Button inputs and pre-entry display fields between controller and display.
interface park_entry_if;
  import park_pkg::*;
  logic btn_a, btn_b, btn_enter, btn_exit_a, btn_exit_b;
  logic [CNT_W-1:0]   current, total_a, total_b, left_a, left_b;
  logic [PRICE_W-1:0] price_start_a, price_start_b, price_add_a, price_add_b;
  logic               gate_open, full_err;

  modport master (
    input  btn_a, btn_b, btn_enter, btn_exit_a, btn_exit_b,
    output current, total_a, total_b, left_a, left_b,
           price_start_a, price_start_b, price_add_a, price_add_b,
           gate_open, full_err
  );
  modport slave (
    output btn_a, btn_b, btn_enter, btn_exit_a, btn_exit_b,
    input  current, total_a, total_b, left_a, left_b,
           price_start_a, price_start_b, price_add_a, price_add_b,
           gate_open, full_err
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and registered rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  // Reset assumes "pressed" so a button held through reset never yields a pulse;
  // an idle button just debounces down to 0 silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_q <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end
endmodule

// File: rtl/park_entry_controller.sv
// Park selection / entry FSM, gate timer and per-park free-space counters
// feeding the pre-entry display.
module park_entry_controller
  import park_pkg::*;
#(
  parameter int TOTAL_A         = 5,
  parameter int TOTAL_B         = 7,
  parameter int PRICE_START_A   = 2,
  parameter int PRICE_START_B   = 3,
  parameter int PRICE_ADD_A     = 1,
  parameter int PRICE_ADD_B     = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int GATE_CYCLES     = 300_000_000
) (
  input  logic         clk,
  input  logic         rst,
  park_entry_if.master bus
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  logic [NUM_BTN-1:0] raw, press;
  assign raw = {bus.btn_exit_b, bus.btn_exit_a, bus.btn_enter, bus.btn_b, bus.btn_a};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .btn   (raw),
    .press (press)
  );

  state_t           state;
  logic [CNT_W-1:0] current, left_a, left_b, sel_left;
  logic [GW-1:0]    gate_cnt;
  logic             gate_open, full_err;
  logic             reselect, try_enter, accept, dec_a, dec_b, inc_a, inc_b;

  always_comb begin
    sel_left  = (current == PARK_A) ? left_a : left_b;
    reselect  = press[BTN_A] | press[BTN_B];
    try_enter = (state == SEL) && press[BTN_ENTER] && !reselect;
    accept    = try_enter && (sel_left != '0);
    dec_a     = accept && (current == PARK_A);
    dec_b     = accept && (current == PARK_B);
    inc_a     = press[BTN_EXIT_A] && (left_a < CNT_W'(TOTAL_A));
    inc_b     = press[BTN_EXIT_B] && (left_b < CNT_W'(TOTAL_B));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      current   <= PARK_NONE;
      gate_open <= 1'b0;
      full_err  <= 1'b0;
      gate_cnt  <= '0;
    end else begin
      full_err <= 1'b0;
      case (state)
        IDLE: begin
          if (press[BTN_A]) begin
            current <= PARK_A;
            state   <= SEL;
          end else if (press[BTN_B]) begin
            current <= PARK_B;
            state   <= SEL;
          end
        end
        SEL: begin
          if (press[BTN_A])      current <= PARK_A;
          else if (press[BTN_B]) current <= PARK_B;
          else if (accept) begin
            gate_open <= 1'b1;
            gate_cnt  <= '0;
            state     <= GATE;
          end else if (try_enter) begin
            full_err <= 1'b1;
          end
        end
        GATE: begin
          if (gate_cnt == GW'(GATE_CYCLES - 1)) begin
            gate_open <= 1'b0;
            current   <= PARK_NONE;
            state     <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A car leaving the same park it is being admitted to nets to no change.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_a <= CNT_W'(TOTAL_A);
      left_b <= CNT_W'(TOTAL_B);
    end else begin
      if (dec_a && press[BTN_EXIT_A]) left_a <= left_a;
      else if (dec_a)                 left_a <= left_a - 1'b1;
      else if (inc_a)                 left_a <= left_a + 1'b1;
      if (dec_b && press[BTN_EXIT_B]) left_b <= left_b;
      else if (dec_b)                 left_b <= left_b - 1'b1;
      else if (inc_b)                 left_b <= left_b + 1'b1;
    end
  end

  assign bus.current       = current;
  assign bus.left_a        = left_a;
  assign bus.left_b        = left_b;
  assign bus.gate_open     = gate_open;
  assign bus.full_err      = full_err;
  assign bus.total_a       = CNT_W'(TOTAL_A);
  assign bus.total_b       = CNT_W'(TOTAL_B);
  assign bus.price_start_a = PRICE_W'(PRICE_START_A);
  assign bus.price_start_b = PRICE_W'(PRICE_START_B);
  assign bus.price_add_a   = PRICE_W'(PRICE_ADD_A);
  assign bus.price_add_b   = PRICE_W'(PRICE_ADD_B);
endmodule

// File: tb/tb_park_entry_controller.sv
// Directed bench for park_entry_controller with DEBOUNCE_CYCLES=4, GATE_CYCLES=10.
module tb_park_entry_controller;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  park_entry_if bus ();

  park_entry_controller #(
    .TOTAL_A(5), .TOTAL_B(7), .PRICE_START_A(2), .PRICE_START_B(3),
    .PRICE_ADD_A(1), .PRICE_ADD_B(2), .DEBOUNCE_CYCLES(4), .GATE_CYCLES(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++;
    if ({bus.current, bus.gate_open, bus.full_err} !== {3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl: cur=%0d gate=%b ferr=%b exp 0/0/0", bus.current, bus.gate_open, bus.full_err);
    end
    checks++;
    if ({bus.left_a, bus.left_b} !== {3'd5, 3'd7}) begin
      errors++; $display("FAIL reset_left: a=%0d b=%0d exp 5/7", bus.left_a, bus.left_b);
    end
    checks++;
    if ({bus.total_a, bus.total_b, bus.price_start_a, bus.price_start_b, bus.price_add_a, bus.price_add_b}
        !== {3'd5, 3'd7, 2'd2, 2'd3, 2'd1, 2'd2}) begin
      errors++; $display("FAIL reset_consts: ta=%0d tb=%0d psa=%0d psb=%0d paa=%0d pab=%0d exp 5 7 2 3 1 2",
        bus.total_a, bus.total_b, bus.price_start_a, bus.price_start_b, bus.price_add_a, bus.price_add_b);
    end
    rst = 1'b0;
    tick(12);
    checks++;
    if ({bus.current, bus.gate_open, bus.price_start_b} !== {3'd0, 1'b0, 2'd3}) begin
      errors++; $display("FAIL idle: cur=%0d gate=%b psb=%0d exp 0/0/3", bus.current, bus.gate_open, bus.price_start_b);
    end
  endtask

  task automatic test_select_enter;
    bus.btn_b = 1'b1;
    tick(7);
    checks++;
    if (bus.current !== 3'd0) begin errors++; $display("FAIL sel_b_early: cur=%0d exp 0", bus.current); end
    tick(1);
    checks++;
    if (bus.current !== 3'd2) begin errors++; $display("FAIL sel_b: cur=%0d exp 2", bus.current); end
    tick(12);
    bus.btn_b = 1'b0;
    tick(12);
    bus.btn_enter = 1'b1;
    tick(7);
    checks++;
    if ({bus.gate_open, bus.left_b} !== {1'b0, 3'd7}) begin
      errors++; $display("FAIL enter_b_early: gate=%b left_b=%0d exp 0/7", bus.gate_open, bus.left_b);
    end
    tick(1);
    checks++;
    if ({bus.gate_open, bus.left_b, bus.current} !== {1'b1, 3'd6, 3'd2}) begin
      errors++; $display("FAIL enter_b: gate=%b left_b=%0d cur=%0d exp 1/6/2", bus.gate_open, bus.left_b, bus.current);
    end
    for (int i = 1; i < 10; i++) begin
      tick(1);
      checks++;
      if ({bus.gate_open, bus.current} !== {1'b1, 3'd2}) begin
        errors++; $display("FAIL gate_hold[%0d]: gate=%b cur=%0d exp 1/2", i, bus.gate_open, bus.current);
      end
    end
    tick(1);
    checks++;
    if ({bus.gate_open, bus.current} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL gate_close: gate=%b cur=%0d exp 0/0", bus.gate_open, bus.current);
    end
    tick(2);
    bus.btn_enter = 1'b0;
    tick(12);
  endtask

  task automatic test_bounce_gate;
    for (int k = 0; k < 3; k++) begin
      bus.btn_a = 1'b1; tick(3);
      bus.btn_a = 1'b0; tick(3);
      checks++;
      if (bus.current !== 3'd0) begin errors++; $display("FAIL bounce[%0d]: cur=%0d exp 0", k, bus.current); end
    end
    bus.btn_a = 1'b1;
    tick(7);
    checks++;
    if (bus.current !== 3'd0) begin errors++; $display("FAIL bounce_early: cur=%0d exp 0", bus.current); end
    tick(1);
    checks++;
    if (bus.current !== 3'd1) begin errors++; $display("FAIL bounce_sel: cur=%0d exp 1", bus.current); end
    tick(4);
    bus.btn_a = 1'b0;
    tick(12);
    bus.btn_enter = 1'b1;
    tick(8);
    checks++;
    if ({bus.gate_open, bus.left_a} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL enter_a: gate=%b left_a=%0d exp 1/4", bus.gate_open, bus.left_a);
    end
    bus.btn_b = 1'b1;
    for (int i = 1; i < 10; i++) begin
      tick(1);
      checks++;
      if ({bus.gate_open, bus.current} !== {1'b1, 3'd1}) begin
        errors++; $display("FAIL gate_ignore_b[%0d]: gate=%b cur=%0d exp 1/1", i, bus.gate_open, bus.current);
      end
    end
    tick(1);
    checks++;
    if ({bus.gate_open, bus.current} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL gate_a_close: gate=%b cur=%0d exp 0/0", bus.gate_open, bus.current);
    end
    tick(2);
    bus.btn_b = 1'b0;
    bus.btn_enter = 1'b0;
    tick(12);
    checks++;
    if ({bus.gate_open, bus.current} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL after_gate_a: gate=%b cur=%0d exp 0/0", bus.gate_open, bus.current);
    end
  endtask

  task automatic test_full;
    for (int n = 0; n < 4; n++) begin
      bus.btn_a = 1'b1; tick(10); bus.btn_a = 1'b0; tick(10);
      bus.btn_enter = 1'b1; tick(10); bus.btn_enter = 1'b0; tick(12);
      checks++;
      if ({bus.left_a, bus.gate_open, bus.current} !== {3'(3 - n), 1'b0, 3'd0}) begin
        errors++; $display("FAIL drain[%0d]: left_a=%0d gate=%b cur=%0d exp %0d/0/0", n, bus.left_a, bus.gate_open, bus.current, 3 - n);
      end
    end
    bus.btn_a = 1'b1; tick(10); bus.btn_a = 1'b0; tick(10);
    bus.btn_enter = 1'b1;
    tick(7);
    checks++;
    if (bus.full_err !== 1'b0) begin errors++; $display("FAIL full_early: ferr=%b exp 0", bus.full_err); end
    tick(1);
    checks++;
    if ({bus.full_err, bus.gate_open} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL full_pulse: ferr=%b gate=%b exp 1/0", bus.full_err, bus.gate_open);
    end
    tick(1);
    checks++;
    if ({bus.full_err, bus.gate_open, bus.current, bus.left_a} !== {1'b0, 1'b0, 3'd1, 3'd0}) begin
      errors++; $display("FAIL full_after: ferr=%b gate=%b cur=%0d left_a=%0d exp 0/0/1/0",
        bus.full_err, bus.gate_open, bus.current, bus.left_a);
    end
    tick(5);
    bus.btn_enter = 1'b0;
    tick(12);
    bus.btn_exit_a = 1'b1;
    tick(7);
    checks++;
    if (bus.left_a !== 3'd0) begin errors++; $display("FAIL exit_a_early: left_a=%0d exp 0", bus.left_a); end
    tick(1);
    checks++;
    if (bus.left_a !== 3'd1) begin errors++; $display("FAIL exit_a: left_a=%0d exp 1", bus.left_a); end
    tick(4);
    bus.btn_exit_a = 1'b0;
    tick(12);
  endtask

  task automatic test_exit_sat;
    bus.btn_exit_b = 1'b1;
    tick(8);
    checks++;
    if (bus.left_b !== 3'd7) begin errors++; $display("FAIL exit_b_inc: left_b=%0d exp 7", bus.left_b); end
    tick(4); bus.btn_exit_b = 1'b0; tick(12);
    bus.btn_exit_b = 1'b1;
    tick(8);
    checks++;
    if (bus.left_b !== 3'd7) begin errors++; $display("FAIL exit_b_sat: left_b=%0d exp 7", bus.left_b); end
    tick(4); bus.btn_exit_b = 1'b0; tick(12);
    checks++;
    if (bus.left_b !== 3'd7) begin errors++; $display("FAIL exit_b_sat_after: left_b=%0d exp 7", bus.left_b); end
  endtask

  task automatic test_back_to_back;
    bus.btn_exit_a = 1'b1;
    bus.btn_enter  = 1'b1;
    tick(7);
    checks++;
    if ({bus.gate_open, bus.left_a} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL same_cycle_early: gate=%b left_a=%0d exp 0/1", bus.gate_open, bus.left_a);
    end
    tick(1);
    checks++;
    if ({bus.gate_open, bus.left_a, bus.current} !== {1'b1, 3'd1, 3'd1}) begin
      errors++; $display("FAIL same_cycle: gate=%b left_a=%0d cur=%0d exp 1/1/1", bus.gate_open, bus.left_a, bus.current);
    end
    tick(12);
    checks++;
    if ({bus.gate_open, bus.current, bus.left_a} !== {1'b0, 3'd0, 3'd1}) begin
      errors++; $display("FAIL same_cycle_after: gate=%b cur=%0d left_a=%0d exp 0/0/1", bus.gate_open, bus.current, bus.left_a);
    end
    bus.btn_exit_a = 1'b0;
    bus.btn_enter  = 1'b0;
    tick(12);
  endtask

  task automatic test_reset_gate;
    bus.btn_b = 1'b1; tick(10); bus.btn_b = 1'b0; tick(10);
    bus.btn_enter = 1'b1;
    tick(8);
    checks++;
    if ({bus.gate_open, bus.left_b} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL rg_open: gate=%b left_b=%0d exp 1/6", bus.gate_open, bus.left_b);
    end
    tick(5);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({bus.gate_open, bus.current, bus.left_a, bus.left_b, bus.full_err} !== {1'b0, 3'd0, 3'd5, 3'd7, 1'b0}) begin
      errors++; $display("FAIL rg_reset: gate=%b cur=%0d left_a=%0d left_b=%0d ferr=%b exp 0/0/5/7/0",
        bus.gate_open, bus.current, bus.left_a, bus.left_b, bus.full_err);
    end
    rst = 1'b0;
    tick(20);
    checks++;
    if ({bus.gate_open, bus.current, bus.left_b} !== {1'b0, 3'd0, 3'd7}) begin
      errors++; $display("FAIL rg_held_btn: gate=%b cur=%0d left_b=%0d exp 0/0/7", bus.gate_open, bus.current, bus.left_b);
    end
    bus.btn_enter = 1'b0;
    tick(12);
    bus.btn_a = 1'b1;
    tick(8);
    checks++;
    if (bus.current !== 3'd1) begin errors++; $display("FAIL rg_resel: cur=%0d exp 1", bus.current); end
    bus.btn_a = 1'b0;
    tick(12);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_a = 1'b0; bus.btn_b = 1'b0; bus.btn_enter = 1'b0;
    bus.btn_exit_a = 1'b0; bus.btn_exit_b = 1'b0;
    test_reset;
    test_select_enter;
    test_bounce_gate;
    test_full;
    test_exit_sat;
    test_back_to_back;
    test_reset_gate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/park_entry_controller.md
# park_entry_controller

Producer side of the pre-entry display interface. It turns raw push buttons into the park-selection and occupancy values that the scrolling pre-entry display reads: `current`, totals, free spaces and price fields for parks A and B. It debounces the buttons, lets a driver select a park and confirm entry, and drives a timed gate-open signal. It also tracks cars leaving each park.

## Interface
- TOTAL_A, 5: capacity of park A (1..7).
- TOTAL_B, 7: capacity of park B (1..7).
- PRICE_START_A / PRICE_START_B, 2 / 3: start price per park (0..3).
- PRICE_ADD_A / PRICE_ADD_B, 1 / 2: per-hour add-on price per park (0..3).
- DEBOUNCE_CYCLES, 2_000_000: stable-level cycles needed to accept a button (20 ms at 100 MHz).
- GATE_CYCLES, 300_000_000: gate-open duration in cycles (3 s).
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- btn_a, btn_b, btn_enter, btn_exit_a, btn_exit_b  in  1 each  raw asynchronous buttons, active-high.
- current  out  3  selected park: 0 = none, 1 = A, 2 = B.
- total_a, total_b  out  3  constant capacities (TOTAL_A, TOTAL_B).
- left_a, left_b  out  3  free spaces per park.
- price_start_a, price_start_b, price_add_a, price_add_b  out  2 each  constant price parameters.
- gate_open  out  1  entry gate drive.
- full_err  out  1  one-cycle pulse: entry refused because the park is full.

## Operation
- Each button passes through a 2-flop synchronizer and a debouncer. A rising edge of the debounced level gives a one-cycle press pulse. Releases produce no pulse.
- FSM states and transitions:
  - IDLE: current=0.
    - press_a goes to SEL with current=1.
    - press_b goes to SEL with current=2.
    - press_a and press_b in the same cycle: A wins.
    - press_enter is ignored.
  - SEL: current holds the selection.
    - press_a or press_b reselects, A wins if both.
    - press_enter with the selected left > 0: decrement that left, set gate_open=1, go to GATE.
    - press_enter with the selected left = 0: pulse full_err and stay in SEL.
  - GATE: gate_open=1 and current held. A counter runs GATE_CYCLES cycles. At expiry: gate_open=0, current=0, go to IDLE. All selection and enter presses are ignored.
- Exit handling is independent of FSM state:
  - press_exit_x increments left_x only if left_x < total_x. Otherwise it is ignored, so left never wraps.
  - An exit and an accepted entry on the same park in the same cycle net to zero change, with the gate still opening.
- Reset values:
  - current=0, gate_open=0, full_err=0.
  - left_a=TOTAL_A, left_b=TOTAL_B.
  - FSM in IDLE; debounce and gate counters at 0.
- Constant outputs equal their parameters at all times, including during reset.
- Arithmetic: left counters are 3-bit unsigned and saturate at 0 and at total. Gate and debounce counters are sized with $clog2 of their parameter.

## Timing
- Debouncer: the counter resets on any change of the synchronized level. The debounced level changes once the synchronized level has been stable for DEBOUNCE_CYCLES consecutive cycles.
- Raw button rising edge (held high) to registered output change (current, left_x, gate_open, full_err) is exactly DEBOUNCE_CYCLES+4 clk edges.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- gate_open is high for exactly GATE_CYCLES cycles. current returns to 0 on the same edge that gate_open falls.
- full_err is high for exactly one cycle per refused press.
- rst asserted in any state, including mid-GATE or mid-debounce, returns all state to reset values on the next edge. A button held through reset produces no pulse until it is released and pressed again.

## Structure
- Shared package/header `park_pkg`:
  - park IDs PARK_NONE=0, PARK_A=1, PARK_B=2.
  - FSM state encoding IDLE, SEL, GATE.
  - 3-bit count and 2-bit price width constants.
- Sub-module `btn_debounce` (synchronizer, debouncer and edge pulse, parameter DEBOUNCE_CYCLES), instantiated five times.
- The FSM, gate counter and left counters live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and GATE_CYCLES=10.
- Reset, then idle -> current=0, left_a=5, left_b=7, gate_open=0, price_start_b=3.
- btn_b held 20 cycles, then btn_enter held 20 cycles -> current=2 exactly 8 edges after the btn_b rise; left_b=6 and gate_open=1 for 10 cycles; then current=0.
- btn_a bounce of 3-cycle pulses, then held -> exactly one selection. While in GATE, btn_b presses do not change current.
- Drain park A with 5 select+enter sequences, then one more enter -> left_a=0 and a single 1-cycle full_err pulse, gate_open stays 0. Then btn_exit_a -> left_a=1.
- btn_exit_b pressed while left_b=7 -> left_b stays 7. btn_exit_a and an accepted enter on A debounced in the same cycle -> left_a unchanged and gate opens.
- rst asserted 5 cycles into GATE -> next edge gate_open=0, current=0, left values back to TOTAL.
